// File: rtl/spart_buffered_driver.sv
// spart_buffered_driver
// Bus master for the SPART peripheral. It programs the baud divisor selected
// by br_cfg and reprograms it whenever br_cfg changes. Every received byte is
// read into an echo FIFO and written back to the transmitter when tbr allows.
//
// Ports
//   clk, rst_n          system clock (rising edge), async active-low reset
//   br_cfg[1:0]         baud select: 00=4800 01=9600 10=19200 11=38400
//   iocs, iorw, ioaddr  SPART bus control (one-cycle accesses)
//   rda, tbr            SPART receive-available / transmit-ready
//   databus[7:0]        bidirectional data, driven only on writes
//   fifo_count          bytes currently buffered
//   overflow            sticky: a byte arrived while the FIFO was full
module spart_buffered_driver #(
    parameter int CLK_HZ = 50_000_000,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               br_cfg,
    output logic                     iocs,
    output logic                     iorw,
    output logic [1:0]               ioaddr,
    input  logic                     rda,
    input  logic                     tbr,
    inout  wire  [7:0]               databus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (16 * 4800)  - 1);
    localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (16 * 9600)  - 1);
    localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (16 * 19200) - 1);
    localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / (16 * 38400) - 1);

    typedef enum logic [1:0] {PROG_LO, PROG_HI, RUN} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cfg_q;
    logic            en_q;
    logic            rd_holdoff, wr_holdoff;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      dout;
    logic [1:0]      div_cfg;
    logic [15:0]     div_sel;
    logic            rd_en, wr_en, latch_cfg;
    logic            full, empty;

    assign full  = (fifo_count == (AW+1)'(DEPTH));
    assign empty = (fifo_count == '0);

    // PROG_LO programs the low byte from the live br_cfg (it is latched in the
    // same cycle); PROG_HI uses the latched copy so both halves match.
    assign div_cfg = (state_q == PROG_LO) ? br_cfg : cfg_q;

    always_comb begin
        case (div_cfg)
            2'b00:   div_sel = DIV_4800;
            2'b01:   div_sel = DIV_9600;
            2'b10:   div_sel = DIV_19200;
            default: div_sel = DIV_38400;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        iocs      = 1'b0;
        iorw      = 1'b1;
        ioaddr    = 2'b00;
        dout      = 8'h00;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        latch_cfg = 1'b0;
        case (state_q)
            PROG_LO: begin
                // en_q keeps the bus idle until the first clock after reset release
                if (en_q) begin
                    iocs      = 1'b1;
                    iorw      = 1'b0;
                    ioaddr    = 2'b10;
                    dout      = div_sel[7:0];
                    latch_cfg = 1'b1;
                    state_d   = PROG_HI;
                end
            end
            PROG_HI: begin
                iocs    = 1'b1;
                iorw    = 1'b0;
                ioaddr  = 2'b11;
                dout    = div_sel[15:8];
                state_d = RUN;
            end
            RUN: begin
                if (br_cfg != cfg_q) begin
                    state_d = PROG_LO;
                end else if (rda && !rd_holdoff) begin
                    iocs  = 1'b1;
                    iorw  = 1'b1;
                    rd_en = 1'b1;
                end else if (!empty && tbr && !wr_holdoff) begin
                    iocs  = 1'b1;
                    iorw  = 1'b0;
                    dout  = mem[rd_ptr];
                    wr_en = 1'b1;
                end
            end
            default: state_d = PROG_LO;
        endcase
    end

    assign databus = (iocs && !iorw) ? dout : 8'hzz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PROG_LO;
            cfg_q      <= 2'b00;
            en_q       <= 1'b0;
            rd_holdoff <= 1'b0;
            wr_holdoff <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= 1'b1;
            rd_holdoff <= rd_en;
            wr_holdoff <= wr_en;
            if (latch_cfg) cfg_q <= br_cfg;
            // Read and write are exclusive, so push and pop never coincide.
            if (rd_en) begin
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    fifo_count <= fifo_count + 1'b1;
                end
            end else if (wr_en) begin
                rd_ptr     <= rd_ptr + 1'b1;
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en && !full) mem[wr_ptr] <= databus;
    end

endmodule

// File: tb/tb_spart_buffered_driver.sv
// Directed bench for spart_buffered_driver with a small SPART receive model.
module tb_spart_buffered_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] br_cfg;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    logic       rda, tbr;
    wire  [7:0] databus;
    logic [3:0] fifo_count;
    logic       overflow;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] rx_mem [64];
    logic [5:0] rx_wr = '0;
    logic [5:0] rx_rd = '0;

    logic [9:0] wlog [$];
    bit         alog [$];

    always #5 clk = ~clk;

    spart_buffered_driver #(.CLK_HZ(50_000_000), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw),
        .ioaddr(ioaddr), .rda(rda), .tbr(tbr), .databus(databus),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    // receive side of the SPART: bytes queued by the bench, popped on reads
    assign rda     = (rx_rd != rx_wr);
    assign databus = (iocs && iorw) ? rx_mem[rx_rd] : 8'hzz;

    always @(posedge clk)
        if (iocs && iorw && ioaddr == 2'b00 && rx_rd != rx_wr) rx_rd <= rx_rd + 1'b1;

    // bus monitor, sampled mid low phase
    always @(negedge clk) begin
        #2;
        if (iocs && !iorw) wlog.push_back({ioaddr, databus});
        if (iocs && ioaddr == 2'b00) alog.push_back(iorw);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] b);
        rx_mem[rx_wr] = b;
        rx_wr = rx_wr + 1'b1;
    endtask

    function automatic logic [9:0] wget(input int i);
        return (i < wlog.size()) ? wlog[i] : 10'hxxx;
    endfunction

    initial begin
        int n;
        int wb, ab;
        logic [31:0] zbus;
        zbus   = 32'h000000zz;
        rst_n  = 1'b0;
        br_cfg = 2'b01;
        tbr    = 1'b0;
        cyc(2); #1;
        chk("rst_iocs", {31'd0, iocs}, 32'd0);
        chk("rst_iorw", {31'd0, iorw}, 32'd1);
        chk("rst_ioaddr", {30'd0, ioaddr}, 32'd0);
        chk("rst_bus", {24'd0, databus}, zbus);
        chk("rst_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);

        // divisor programming after release
        @(negedge clk); rst_n = 1'b1; #1;
        n = 0;
        while (!iocs && n < 6) begin @(negedge clk); #1; n++; end
        chk("prog_lo_iocs", {31'd0, iocs}, 32'd1);
        chk("prog_lo_addr", {30'd0, ioaddr}, 32'd2);
        chk("prog_lo_rw", {31'd0, iorw}, 32'd0);
        chk("prog_lo_data", {24'd0, databus}, 32'h44);
        @(negedge clk); #1;
        chk("prog_hi_addr", {30'd0, ioaddr}, 32'd3);
        chk("prog_hi_data", {24'd0, databus}, 32'h01);
        @(negedge clk); #1;
        chk("run_idle", {31'd0, iocs}, 32'd0);

        // single-byte echo
        tbr = 1'b1;
        load(8'h41); #1;
        chk("echo_rd", {30'd0, iocs, iorw}, 32'd3);
        chk("echo_rd_addr", {30'd0, ioaddr}, 32'd0);
        @(negedge clk); #1;
        chk("echo_cnt1", {28'd0, fifo_count}, 32'd1);
        chk("echo_wr", {30'd0, iocs, iorw}, 32'd2);
        chk("echo_wr_data", {24'd0, databus}, 32'h41);
        @(negedge clk); #1;
        chk("echo_cnt0", {28'd0, fifo_count}, 32'd0);

        // burst into a stalled transmitter
        tbr = 1'b0;
        for (int i = 0; i < 9; i++) load(8'h10 + 8'(i));
        cyc(25); #1;
        chk("burst_cnt", {28'd0, fifo_count}, 32'd8);
        chk("burst_ovf", {31'd0, overflow}, 32'd1);
        wb = wlog.size();
        tbr = 1'b1;
        cyc(20); #1;
        chk("burst_nwr", wlog.size() - wb, 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("burst_wr%0d", i), {22'd0, wget(wb + i)}, {22'd0, 2'b00, 8'h10 + 8'(i)});
        chk("burst_drain", {28'd0, fifo_count}, 32'd0);

        // rate change with bytes buffered
        tbr = 1'b0;
        for (int i = 0; i < 3; i++) load(8'h61 + 8'(i));
        cyc(10); #1;
        chk("rate_cnt", {28'd0, fifo_count}, 32'd3);
        wb = wlog.size();
        br_cfg = 2'b11;
        cyc(5); #1;
        chk("rate_lo", {22'd0, wget(wb)}, {22'd0, 10'h250});
        chk("rate_hi", {22'd0, wget(wb + 1)}, {22'd0, 10'h300});
        chk("rate_keep_cnt", {28'd0, fifo_count}, 32'd3);
        chk("rate_keep_ovf", {31'd0, overflow}, 32'd1);
        tbr = 1'b1;
        cyc(10); #1;
        chk("rate_nwr", wlog.size() - wb, 32'd5);
        for (int i = 0; i < 3; i++)
            chk($sformatf("rate_echo%0d", i), {22'd0, wget(wb + 2 + i)}, {22'd0, 2'b00, 8'h61 + 8'(i)});

        // rda and tbr both held high: strict read/write alternation
        wb = wlog.size();
        ab = alog.size();
        for (int i = 0; i < 6; i++) load(8'h71 + 8'(i));
        cyc(16); #1;
        chk("hold_nacc", alog.size() - ab, 32'd12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("hold_seq%0d", i),
                {31'd0, (ab + i < alog.size()) ? alog[ab + i] : 1'bx}, {31'd0, (i % 2 == 0)});
        for (int i = 0; i < 6; i++)
            chk($sformatf("hold_wr%0d", i), {22'd0, wget(wb + i)}, {22'd0, 2'b00, 8'h71 + 8'(i)});

        // reset with bytes buffered
        tbr = 1'b0;
        for (int i = 0; i < 5; i++) load(8'h81 + 8'(i));
        cyc(12); #1;
        chk("mid_cnt", {28'd0, fifo_count}, 32'd5);
        @(negedge clk);
        wb = wlog.size();
        rst_n = 1'b0; #1;
        chk("mid_rst_cnt", {28'd0, fifo_count}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        chk("mid_rst_iocs", {31'd0, iocs}, 32'd0);
        @(negedge clk); rst_n = 1'b1; tbr = 1'b1;
        cyc(8); #1;
        chk("mid_nwr", wlog.size() - wb, 32'd2);
        chk("mid_lo", {22'd0, wget(wb)}, {22'd0, 10'h250});
        chk("mid_hi", {22'd0, wget(wb + 1)}, {22'd0, 10'h300});
        chk("mid_cnt_after", {28'd0, fifo_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
